acc_ctrl_tx_drv: RTL and testbench

Serial transmitter for accelerometer/AOM control words: turns a class request (0–7) into the 16-bit code `0x5A50 + class` and shifts it out on a source-clocked serial link (SPI_SCLK plus SERIAL_MODE data lanes) toward the remote acc-control receiver. It sits on the controller side of the board link. It resends the last code periodically so the far end recovers state after its own reset. A single pending slot lets a new request queue behind a frame in flight; the newest request overwrites an older pending one.

---
 rtl/acc_ctrl_tx_drv.sv | 163 ++++++++++++++++
 tb/tb_acc_ctrl_tx_drv.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl_tx_drv.sv
// rtl/acc_ctrl_tx_drv.sv - serial transmitter for accelerometer/AOM control words
// Source-clocked MSB-first link with one pending slot and optional periodic resend.
module acc_ctrl_tx_drv #(
  parameter int DATA_WIDTH     = 16,
  parameter int SERIAL_MODE    = 1,
  parameter int CLK_DIV        = 2,
  parameter int GAP_BEATS      = 4,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [2:0]             class_i,
  input  logic                   class_valid_i,
  output logic                   busy_o,
  output logic                   tx_done_o,
  output logic                   SPI_SCLK,
  output logic [SERIAL_MODE-1:0] SPI_MOSI
);

  localparam int BEATS   = DATA_WIDTH / SERIAL_MODE;
  localparam int GAP_CYC = GAP_BEATS * 2 * CLK_DIV;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [REF_W-1:0]      REF_LAST  = REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic [DATA_WIDTH-1:0] CODE_BASE = DATA_WIDTH'(16'h5A50);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]   pend_code_q, pend_code_d;
  logic [DATA_WIDTH-1:0]   last_code_q, last_code_d;
  logic                    pend_v_q, pend_v_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   strobe_code;
  logic                    refresh_req;

  assign strobe_code = CODE_BASE | DATA_WIDTH'(class_i);
  assign refresh_req = (REFRESH_CYCLES != 0) && (ref_cnt_q == REF_LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    pend_code_d = pend_code_q;
    pend_v_d    = pend_v_q;
    last_code_d = last_code_q;
    div_d       = div_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    sclk_d      = sclk_q;
    ref_cnt_d   = ref_cnt_q;

    if (REFRESH_CYCLES != 0) begin
      ref_cnt_d = refresh_req ? '0 : ref_cnt_q + 1'b1;
    end

    // A strobe always claims the slot; a resend only fills an empty one.
    if (class_valid_i) begin
      pend_v_d    = 1'b1;
      pend_code_d = strobe_code;
    end else if (refresh_req && !pend_v_q) begin
      pend_v_d    = 1'b1;
      pend_code_d = last_code_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (class_valid_i || pend_v_q) begin
          shreg_d     = class_valid_i ? strobe_code : pend_code_q;
          last_code_d = class_valid_i ? strobe_code : pend_code_q;
          pend_v_d    = 1'b0;
          ref_cnt_d   = '0;
          div_d       = '0;
          beat_d      = '0;
          sclk_d      = 1'b0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Falling edge closes the beat: data moves only while SCLK is low.
          if (sclk_q) begin
            shreg_d = shreg_q << SERIAL_MODE;
            if (beat_q == BEAT_LAST) begin
              beat_d  = '0;
              gap_d   = '0;
              state_d = ST_GAP;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP) && (gap_d == GAP_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      pend_code_q <= '0;
      pend_v_q    <= 1'b0;
      last_code_q <= CODE_BASE;
      div_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      ref_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pend_code_q <= pend_code_d;
      pend_v_q    <= pend_v_d;
      last_code_q <= last_code_d;
      div_q       <= div_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      ref_cnt_q   <= ref_cnt_d;
      sclk_q      <= sclk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign tx_done_o = done_q;
  assign SPI_SCLK  = sclk_q;
  assign SPI_MOSI  = shreg_q[DATA_WIDTH-1 -: SERIAL_MODE];

endmodule

// File: tb/tb_acc_ctrl_tx_drv.sv
// tb/tb_acc_ctrl_tx_drv.sv - self-checking bench for acc_ctrl_tx_drv
// Three instances: single lane, four lanes, single lane with periodic resend.
module tb_acc_ctrl_tx_drv;

  localparam int DW        = 16;
  localparam int CD        = 2;
  localparam int GB        = 4;
  localparam int CODE_BASE = 'h5A50;

  typedef struct {
    int start;
    int code;
    int pv;
    int pc;
    int last;
    int cnt;
  } mstate_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] vld;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] sclk;
  logic [2:0] cls [3];
  logic [0:0] mosi0;
  logic [3:0] mosi1;
  logic [0:0] mosi2;

  int      t        = 0;
  int      n_checks = 0;
  int      n_fail   = 0;
  mstate_t m [3];
  int      rises [3];
  int      first_rise [3];
  int      done_t [3];
  int      fall_t [3];
  int      rx [3];
  int      nstarts [3];
  int      nwords [3];
  int      starts [3][8];
  int      words [3][8];
  logic [2:0] busy_p = '0;
  logic [2:0] sclk_p = '0;

  always #5 clk = ~clk;

  acc_ctrl_tx_drv #(.DATA_WIDTH(DW), .SERIAL_MODE(1), .CLK_DIV(CD), .GAP_BEATS(GB), .REFRESH_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .class_i(cls[0]), .class_valid_i(vld[0]),
    .busy_o(busy[0]), .tx_done_o(done[0]), .SPI_SCLK(sclk[0]), .SPI_MOSI(mosi0));

  acc_ctrl_tx_drv #(.DATA_WIDTH(DW), .SERIAL_MODE(4), .CLK_DIV(CD), .GAP_BEATS(GB), .REFRESH_CYCLES(0)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .class_i(cls[1]), .class_valid_i(vld[1]),
    .busy_o(busy[1]), .tx_done_o(done[1]), .SPI_SCLK(sclk[1]), .SPI_MOSI(mosi1));

  acc_ctrl_tx_drv #(.DATA_WIDTH(DW), .SERIAL_MODE(1), .CLK_DIV(CD), .GAP_BEATS(GB), .REFRESH_CYCLES(200)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n[2]), .class_i(cls[2]), .class_valid_i(vld[2]),
    .busy_o(busy[2]), .tx_done_o(done[2]), .SPI_SCLK(sclk[2]), .SPI_MOSI(mosi2));

  function automatic int sm_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int ref_of(input int i);
    return (i == 2) ? 200 : 0;
  endfunction

  function automatic int bl_of(input int i);
    return (DW / sm_of(i)) * 2 * CD;
  endfunction

  function automatic int fl_of(input int i);
    return bl_of(i) + GB * 2 * CD;
  endfunction

  function automatic int mosi_of(input int i);
    case (i)
      0:       return int'(mosi0);
      1:       return int'(mosi1);
      default: return int'(mosi2);
    endcase
  endfunction

  function automatic mstate_t reset_state();
    mstate_t s;
    s.start = -1;
    s.code  = 0;
    s.pv    = 0;
    s.pc    = 0;
    s.last  = CODE_BASE;
    s.cnt   = 0;
    return s;
  endfunction

  // One clock edge of the transmitter as seen from outside: slot, resend timer, frame launch.
  function automatic mstate_t step(input mstate_t s, input int r, input int fl,
                                   input logic v, input logic [2:0] c, input int te);
    mstate_t n;
    bit      idle;
    bit      refr;
    int      req;
    n    = s;
    req  = CODE_BASE | int'(c);
    idle = (s.start < 0) || (te > s.start + fl);
    refr = (r != 0) && (s.cnt == r - 1);
    n.cnt = (r == 0) ? 0 : (refr ? 0 : s.cnt + 1);
    if (v) begin
      n.pv = 1;
      n.pc = req;
    end else if (refr && s.pv == 0) begin
      n.pv = 1;
      n.pc = s.last;
    end
    if (idle && (v || s.pv != 0)) begin
      n.code  = v ? req : s.pc;
      n.start = te;
      n.last  = n.code;
      n.pv    = 0;
      n.cnt   = 0;
    end
    return n;
  endfunction

  task automatic expect_out(input int i, output int eb, output int ed, output int es, output int em);
    int k;
    int sm;
    eb = 0; ed = 0; es = 0; em = 0;
    sm = sm_of(i);
    if (m[i].start >= 0) begin
      k = t - m[i].start;
      if (k < fl_of(i)) begin
        eb = 1;
        ed = (k == fl_of(i) - 1) ? 1 : 0;
        if (k < bl_of(i)) begin
          es = ((k % (2 * CD)) >= CD) ? 1 : 0;
          em = (m[i].code >> (DW - sm * (k / (2 * CD) + 1))) & ((1 << sm) - 1);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_step();
    t++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) m[i] = reset_state();
      else           m[i] = step(m[i], ref_of(i), fl_of(i), vld[i], cls[i], t);
    end
  endtask

  task automatic compare_cycle();
    int eb, ed, es, em;
    for (int i = 0; i < 3; i++) begin
      eb = 0; ed = 0; es = 0; em = 0;
      if (rst_n[i]) expect_out(i, eb, ed, es, em);
      chk($sformatf("busy%0d", i), int'(busy[i]), eb);
      chk($sformatf("done%0d", i), int'(done[i]), ed);
      chk($sformatf("sclk%0d", i), int'(sclk[i]), es);
      chk($sformatf("mosi%0d", i), mosi_of(i), em);
      if (busy[i] && !busy_p[i]) begin
        if (nstarts[i] < 8) starts[i][nstarts[i]] = t;
        nstarts[i]++;
      end
      if (!busy[i] && busy_p[i]) fall_t[i] = t;
      if (sclk[i] && !sclk_p[i]) begin
        rises[i]++;
        if (first_rise[i] < 0) first_rise[i] = t;
        rx[i] = (rx[i] << sm_of(i)) | mosi_of(i);
      end
      if (done[i]) begin
        done_t[i] = t;
        if (nwords[i] < 8) words[i][nwords[i]] = rx[i] & 'hFFFF;
        nwords[i]++;
        rx[i] = 0;
      end
      busy_p[i] = busy[i];
      sclk_p[i] = sclk[i];
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) compare_cycle();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int i, input logic [2:0] c);
    cls[i] = c;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic clear_logs(input int i);
    rises[i] = 0; first_rise[i] = -1; done_t[i] = -1; fall_t[i] = -1;
    rx[i] = 0; nstarts[i] = 0; nwords[i] = 0;
  endtask

  task automatic wait_words(input int i, input int n, input int bound);
    int k = 0;
    while (nwords[i] < n && k < bound) begin tick(); k++; end
    chk($sformatf("wait_words%0d", i), nwords[i], n);
  endtask

  task automatic wait_starts(input int i, input int n, input int bound);
    int k = 0;
    while (nstarts[i] < n && k < bound) begin tick(); k++; end
    chk($sformatf("wait_starts%0d", i), nstarts[i], n);
  endtask

  task automatic wait_idle(input int i, input int bound);
    int k = 0;
    while (busy[i] && k < bound) begin tick(); k++; end
    chk($sformatf("wait_idle%0d", i), int'(busy[i]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int ec;
    int k;
    rst_n = 3'b000;
    vld   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cls[i] = 3'd0;
      m[i]   = reset_state();
      clear_logs(i);
    end
    repeat (4) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'({mosi2, mosi1, mosi0}), 0);
    rst_n = 3'b111;
    repeat (2) tick();

    // Single frame, class 1
    clear_logs(0);
    e0 = t;
    strobe(0, 3'd1);
    wait_words(0, 1, 200);
    repeat (2) tick();
    chk("a_start_edge", starts[0][0] - e0, 1);
    chk("a_first_rise", first_rise[0] - e0, 3);
    chk("a_pulses", rises[0], 16);
    chk("a_word", words[0][0], 'h5A51);
    chk("a_done_edge", done_t[0] - e0, 80);
    chk("a_busy_fall", fall_t[0] - e0, 81);

    // Newest pending request overwrites the older one
    clear_logs(0);
    e0 = t;
    strobe(0, 3'd1);
    repeat (10) tick();
    strobe(0, 3'd0);
    strobe(0, 3'd3);
    wait_words(0, 2, 400);
    repeat (200) tick();
    chk("b_frames", nstarts[0], 2);
    chk("b_word0", words[0][0], 'h5A51);
    chk("b_word1", words[0][1], 'h5A53);
    chk("b_second_start", starts[0][1] - e0, 82);

    // Four lanes, class 7
    clear_logs(1);
    strobe(1, 3'd7);
    wait_words(1, 1, 100);
    chk("c_beats", rises[1], 4);
    chk("c_word", words[1][0], 'h5A57);

    // Reset in the middle of the fifth beat
    clear_logs(0);
    e0 = t;
    strobe(0, 3'd1);
    while (t < e0 + 19) tick();
    chk("d_sclk_before", int'(sclk[0]), 1);
    chk("d_mosi_before", int'(mosi0), 1);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("d_sclk_async", int'(sclk[0]), 0);
    chk("d_mosi_async", int'(mosi0), 0);
    chk("d_busy_async", int'(busy[0]), 0);
    repeat (3) tick();
    rst_n[0] = 1'b1;
    clear_logs(0);
    repeat (100) tick();
    chk("d_no_sclk", rises[0], 0);
    chk("d_no_frame", nstarts[0], 0);

    // Periodic resend of the reset code
    wait_idle(2, 300);
    clear_logs(2);
    wait_starts(2, 2, 600);
    chk("e_period", starts[2][1] - starts[2][0], 201);
    chk("e_word0", words[2][0], 'h5A50);

    // Resend follows the latest requested class
    wait_idle(2, 300);
    clear_logs(2);
    strobe(2, 3'd2);
    wait_words(2, 2, 700);
    chk("e_req_word", words[2][0], 'h5A52);
    chk("e_ref_word", words[2][1], 'h5A52);

    // Strobe collides with the resend request
    wait_idle(2, 300);
    k = 0;
    while (!(m[2].cnt == 199 && m[2].pv == 0 && (t + 1) > m[2].start + fl_of(2)) && k < 600) begin
      tick();
      k++;
    end
    chk("f_sync", (k < 600) ? 1 : 0, 1);
    clear_logs(2);
    strobe(2, 3'd4);
    ec = t;
    repeat (150) tick();
    chk("f_frames", nstarts[2], 1);
    chk("f_start_edge", starts[2][0] - ec, 0);
    chk("f_word", words[2][0], 'h5A54);
    wait_starts(2, 2, 300);
    chk("f_next_refresh", starts[2][1] - ec, 201);
    wait_words(2, 2, 100);
    chk("f_refresh_word", words[2][1], 'h5A54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
